// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one-word fetches to a 1-cycle IM
// and buffers {instruction, pc} pairs in a small ring queue feeding the ID stage.
module if_fetch_queue #(
  parameter int DW    = 32,
  parameter int AW    = 30,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = 'h0000_0C00
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       im_req,
  output logic [AW-1:0]              im_addr,
  input  logic                       im_rsp_vld,
  input  logic [DW-1:0]              im_rsp_ins,
  input  logic                       redir_vld,
  input  logic [AW-1:0]              redir_pc,
  output logic                       id_valid,
  output logic [DW-1:0]              id_ins,
  output logic [AW-1:0]              id_pc,
  input  logic                       id_ready,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_pc;
  logic          inflight;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [DW-1:0] ins_mem [DEPTH];
  logic [AW-1:0] pc_mem  [DEPTH];

  logic [CW:0]   used;
  logic          issue;
  logic          push;
  logic          pop;

  // Credit check counts the outstanding fetch, so a response always finds a free slot.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue = rst && !redir_vld && (used < (CW+1)'(DEPTH));
  assign push  = im_rsp_vld && inflight && !redir_vld;
  assign pop   = (count != '0) && id_ready && !redir_vld;

  assign im_req   = issue;
  assign im_addr  = fetch_pc;
  assign id_valid = (count != '0);
  assign id_ins   = ins_mem[head];
  assign id_pc    = pc_mem[head];
  assign q_count  = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redir_vld) begin
      fetch_pc <= redir_pc;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + AW'(1);
        req_pc   <= fetch_pc;
      end
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[tail] <= im_rsp_ins;
      pc_mem[tail]  <= req_pc;
    end
  end

endmodule
